input_conditioner: RTL

Per-button synchroniser, debouncer, edge detector and autorepeat generator for the DE2-115 push-buttons. It sits directly upstream of the `vga` game block. Its inputs are the board wrapper's already-inverted, active-high KEY lines. It delivers clean levels plus single-cycle press, release and action pulses to the game logic. One instance covers all buttons; each channel is independent and identical.

---
 rtl/input_conditioner.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/input_conditioner.sv
// input_conditioner: per-button synchroniser, debouncer, press/release edge
// detector and autorepeat generator. Every channel is an identical,
// independent copy of the same pipeline:
//   btn_raw -> 2-flop sync -> debounce (accepted level) -> output register
// The autorepeat FSM runs alongside the accepted level. Its pulse is
// registered through the same output stage as the press pulse, so press,
// release and action all line up with the first cycle btn_level changes.
module input_conditioner #(
    parameter int              NBTN            = 4,
    parameter int              DEBOUNCE_CYCLES = 500000,
    parameter int              REPEAT_DELAY    = 15000000,
    parameter int              REPEAT_PERIOD   = 5000000,
    parameter logic [NBTN-1:0] REPEAT_MASK     = 4'b0100
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NBTN-1:0] btn_raw,
    output logic [NBTN-1:0] btn_level,
    output logic [NBTN-1:0] btn_press,
    output logic [NBTN-1:0] btn_release,
    output logic [NBTN-1:0] btn_action
);

    localparam int DW   = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = (RMAX > 2) ? $clog2(RMAX) : 1;

    localparam logic [DW-1:0] D_LAST  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RW-1:0] RD_LAST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RP_LAST = RW'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_REPEAT = 2'd2
    } rep_state_t;

    genvar gi;
    generate
        for (gi = 0; gi < NBTN; gi++) begin : g_chan
            logic            r_s1;
            logic            r_s2;
            logic            r_lvl;
            logic [DW-1:0]   r_dcnt;
            logic            r_acc_rise;
            logic            r_acc_fall;
            logic            r_rep;
            logic            r_out_lvl;
            logic            r_out_press;
            logic            r_out_rel;
            logic            r_out_act;
            rep_state_t      r_state;
            rep_state_t      w_state_next;
            logic [RW-1:0]   r_rcnt;
            logic [RW-1:0]   w_rcnt_next;
            logic            w_rep;
            logic            w_acc_rise;
            logic            w_acc_fall;

            // Level change accepted on this edge (the counter has run out while s2 differs)
            assign w_acc_rise = (r_s2 != r_lvl) && (r_dcnt == D_LAST) && r_s2;
            assign w_acc_fall = (r_s2 != r_lvl) && (r_dcnt == D_LAST) && !r_s2;

            // Two-flop synchroniser for the asynchronous raw button
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_s1 <= 1'b0;
                    r_s2 <= 1'b0;
                end else begin
                    r_s1 <= btn_raw[gi];
                    r_s2 <= r_s1;
                end
            end

            // Debounce: count consecutive cycles of disagreement, restart on any agreement
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_lvl      <= 1'b0;
                    r_dcnt     <= '0;
                    r_acc_rise <= 1'b0;
                    r_acc_fall <= 1'b0;
                end else begin
                    r_acc_rise <= w_acc_rise;
                    r_acc_fall <= w_acc_fall;
                    if (r_s2 == r_lvl) begin
                        r_dcnt <= '0;
                    end else if (r_dcnt == D_LAST) begin
                        r_lvl  <= r_s2;
                        r_dcnt <= '0;
                    end else begin
                        r_dcnt <= r_dcnt + 1'b1;
                    end
                end
            end

            // Autorepeat state register, counter and registered repeat pulse
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_state <= ST_IDLE;
                    r_rcnt  <= '0;
                    r_rep   <= 1'b0;
                end else begin
                    r_state <= w_state_next;
                    r_rcnt  <= w_rcnt_next;
                    r_rep   <= w_rep;
                end
            end

            // Autorepeat next state; a masked-off channel never leaves IDLE
            always_comb begin
                w_state_next = r_state;
                case (r_state)
                    ST_IDLE: begin
                        if (w_acc_rise && REPEAT_MASK[gi])
                            w_state_next = ST_DELAY;
                    end
                    ST_DELAY: begin
                        if (w_acc_fall)
                            w_state_next = ST_IDLE;
                        else if (r_rcnt == RD_LAST)
                            w_state_next = ST_REPEAT;
                    end
                    ST_REPEAT: begin
                        if (w_acc_fall)
                            w_state_next = ST_IDLE;
                    end
                    default: w_state_next = ST_IDLE;
                endcase
            end

            // Autorepeat outputs: counter update and pulse; an accepted release wins over a pulse
            always_comb begin
                w_rep       = 1'b0;
                w_rcnt_next = r_rcnt;
                case (r_state)
                    ST_IDLE: begin
                        w_rcnt_next = '0;
                    end
                    ST_DELAY: begin
                        if (w_acc_fall) begin
                            w_rcnt_next = '0;
                        end else if (r_rcnt == RD_LAST) begin
                            w_rep       = 1'b1;
                            w_rcnt_next = '0;
                        end else begin
                            w_rcnt_next = r_rcnt + 1'b1;
                        end
                    end
                    ST_REPEAT: begin
                        if (w_acc_fall) begin
                            w_rcnt_next = '0;
                        end else if (r_rcnt == RP_LAST) begin
                            w_rep       = 1'b1;
                            w_rcnt_next = '0;
                        end else begin
                            w_rcnt_next = r_rcnt + 1'b1;
                        end
                    end
                    default: w_rcnt_next = '0;
                endcase
            end

            // Output stage: level and all pulses change together on the same edge
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_out_lvl   <= 1'b0;
                    r_out_press <= 1'b0;
                    r_out_rel   <= 1'b0;
                    r_out_act   <= 1'b0;
                end else begin
                    r_out_lvl   <= r_lvl;
                    r_out_press <= r_acc_rise;
                    r_out_rel   <= r_acc_fall;
                    r_out_act   <= r_acc_rise | r_rep;
                end
            end

            assign btn_level[gi]   = r_out_lvl;
            assign btn_press[gi]   = r_out_press;
            assign btn_release[gi] = r_out_rel;
            assign btn_action[gi]  = r_out_act;
        end
    endgenerate

endmodule
